// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between two requesters.
// Latency: accept in T, response valid from T+2; each response holds until its ready.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_srca,
  input  logic [WIDTH-1:0] req0_srcb,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_srca,
  input  logic [WIDTH-1:0] req1_srcb,
  input  logic [2:0]       req1_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  logic             r_prio;
  logic             r_winner;
  logic [WIDTH-1:0] r_srca;
  logic [WIDTH-1:0] r_srcb;
  logic [2:0]       r_ctrl;
  logic             r_rsp0_valid;
  logic             r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_err;

  logic w_grant0;
  logic w_grant1;
  logic w_illegal;
  logic w_rsp_done;

  // prio breaks the tie only when both requesters are valid
  assign w_grant0   = (r_state == IDLE) && req0_valid && (!req1_valid || !r_prio);
  assign w_grant1   = (r_state == IDLE) && req1_valid && (!req0_valid ||  r_prio);
  assign w_illegal  = (r_ctrl == 3'b011) || (r_ctrl == 3'b100) || (r_ctrl == 3'b101);
  assign w_rsp_done = (r_rsp0_valid && rsp0_ready) || (r_rsp1_valid && rsp1_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_prio       <= 1'b0;
      r_winner     <= 1'b0;
      r_srca       <= '0;
      r_srcb       <= '0;
      r_ctrl       <= 3'b010;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant0) begin
            r_srca   <= req0_srca;
            r_srcb   <= req0_srcb;
            r_ctrl   <= req0_ctrl;
            r_winner <= 1'b0;
            r_prio   <= 1'b1;
            r_state  <= EXEC;
          end else if (w_grant1) begin
            r_srca   <= req1_srca;
            r_srcb   <= req1_srcb;
            r_ctrl   <= req1_ctrl;
            r_winner <= 1'b1;
            r_prio   <= 1'b0;
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          if (w_illegal) begin
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b1;
            r_rsp_err    <= 1'b1;
          end else begin
            r_rsp_result <= alu_result;
            r_rsp_zero   <= alu_zero;
            r_rsp_err    <= 1'b0;
          end
          r_rsp0_valid <= !r_winner;
          r_rsp1_valid <= r_winner;
          r_state      <= RESP;
        end
        RESP: begin
          if (w_rsp_done) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_zero    = r_rsp_zero;
  assign rsp_err     = r_rsp_err;
  assign alu_srca    = r_srca;
  assign alu_srcb    = r_srcb;
  assign alu_control = r_ctrl;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the ALU ports.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [31:0] alu_srca, alu_srcb, alu_result;
  logic [2:0]  alu_control;
  logic        alu_zero;

  int n_chk  = 0;
  int n_pass = 0;

  alu_arbiter #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Illegal codes return junk so the forced zero result is observable
  always_comb begin
    alu_result = 32'hDEADBEEF;
    case (alu_control)
      3'b000: alu_result = alu_srca & alu_srcb;
      3'b001: alu_result = alu_srca | alu_srcb;
      3'b010: alu_result = alu_srca + alu_srcb;
      3'b110: alu_result = alu_srca - alu_srcb;
      3'b111: alu_result = {31'd0, $signed(alu_srca) < $signed(alu_srcb)};
      default: alu_result = 32'hDEADBEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request in IDLE, confirm the grant, leave the DUT in EXEC
  task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] c);
    if (id == 1'b0) begin
      req0_srca = a; req0_srcb = b; req0_ctrl = c; req0_valid = 1'b1;
    end else begin
      req1_srca = a; req1_srcb = b; req1_ctrl = c; req1_valid = 1'b1;
    end
    #1;
    chk($sformatf("grant%0d", id), {30'd0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
    tick();
    if (id == 1'b0) req0_valid = 1'b0;
    else            req1_valid = 1'b0;
  endtask

  // From EXEC: check the response on the winner, then complete the handshake
  task automatic expect_rsp(input bit id, input logic [31:0] res, input logic z,
                            input logic e);
    tick();
    chk($sformatf("rsp_valid%0d", id), {30'd0, rsp1_valid, rsp0_valid}, id ? 32'd2 : 32'd1);
    chk("rsp_result", rsp_result, res);
    chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, z});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e});
    if (id == 1'b0) rsp0_ready = 1'b1;
    else            rsp1_ready = 1'b1;
    tick();
    chk("rsp_done", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_srca = '0; req0_srcb = '0; req0_ctrl = 3'b000;
    req1_srca = '0; req1_srcb = '0; req1_ctrl = 3'b000;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    tick(); tick();
    chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);
    chk("rst_alu_ctrl", {29'd0, alu_control}, 32'd2);
    chk("rst_alu_srca", alu_srca, 32'd0);
    reset = 1'b1;
    tick();

    // ADD on requester 0
    send(1'b0, 32'd5, 32'd7, 3'b010);
    chk("exec_srca", alu_srca, 32'd5);
    chk("exec_srcb", alu_srcb, 32'd7);
    chk("exec_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    expect_rsp(1'b0, 32'd12, 1'b0, 1'b0);

    // SUB to zero on requester 1
    send(1'b1, 32'h1234, 32'h1234, 3'b110);
    expect_rsp(1'b1, 32'd0, 1'b1, 1'b0);

    // Illegal code, then a legal op clears the error
    send(1'b0, 32'd9, 32'd3, 3'b100);
    expect_rsp(1'b0, 32'd0, 1'b1, 1'b1);
    send(1'b0, 32'd1, 32'd2, 3'b001);
    expect_rsp(1'b0, 32'd3, 1'b0, 1'b0);

    // Backpressure on rsp0 while requester 1 waits and rsp1_ready toggles
    send(1'b0, 32'h10, 32'h20, 3'b010);
    tick();
    req1_srca = 32'd1; req1_srcb = 32'd1; req1_ctrl = 3'b010; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
      chk("bp_result", rsp_result, 32'h30);
      chk("bp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      rsp1_ready = ~rsp1_ready;
      tick();
    end
    chk("bp_hold", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    tick();
    chk("bp_release", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("bp_idle_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
    rsp0_ready = 1'b0;
    tick();
    req1_valid = 1'b0;
    expect_rsp(1'b1, 32'd2, 1'b0, 1'b0);

    // Reset during EXEC, after a requester-0 grant flipped the priority
    send(1'b0, 32'd3, 32'd4, 3'b010);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("mid_rst_result", rsp_result, 32'd0);
    chk("mid_rst_alu", {alu_srca[28:0], alu_control}, {29'd0, 3'b010});
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    tick();
    chk("post_rst_no_rsp2", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

    // Both valid continuously: req0 first (prio reset), then strict alternation
    req0_srca = 32'hF0F0; req0_srcb = 32'hFF00; req0_ctrl = 3'b000;
    req1_srca = 32'hFFFFFFFF; req1_srcb = 32'd1; req1_ctrl = 3'b111;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_grant%0d", k), {30'd0, req1_ready, req0_ready},
          (k % 2 == 1) ? 32'd2 : 32'd1);
      tick();
      tick();
      chk($sformatf("rr_valid%0d", k), {30'd0, rsp1_valid, rsp0_valid},
          (k % 2 == 1) ? 32'd2 : 32'd1);
      chk($sformatf("rr_result%0d", k), rsp_result, (k % 2 == 1) ? 32'd1 : 32'hF000);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
